// File: rtl/osc_tester_pkg.sv
// Shared types and defaults for the oscillator tester stimulus path.
// Holds the run-state encoding and the default field widths.
package osc_tester_pkg;

    localparam int HP_W_DEF  = 8;
    localparam int CNT_W_DEF = 8;
    localparam int HP_MIN    = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/osc_half_period_timer.sv
// Loadable half-period down-counter; tick_zero flags the last cycle of a phase.
// A load has priority over counting; the counter parks at zero otherwise.
module osc_half_period_timer
#(
    parameter int HP_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [HP_W-1:0] load_val,
    output logic            tick_zero
);

    logic [HP_W-1:0] cnt_q;
    logic [HP_W-1:0] cnt_d;

    // Next count: reload, decrement, or hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != {HP_W{1'b0}}) begin
            cnt_d = cnt_q - HP_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {HP_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_zero = (cnt_q == {HP_W{1'b0}});

endmodule

// File: rtl/osc_stimulus_gen.sv
// Programmable square-wave stimulus for the oscillator tester loopback path.
// Emits whole periods of 2*hp cycles, counted or continuous, then pulses done.
module osc_stimulus_gen
    import osc_tester_pkg::*;
#(
    parameter int HP_W  = HP_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [HP_W-1:0]  cfg_half_period,
    input  logic [CNT_W-1:0] cfg_periods,
    input  logic             stop,
    output logic             osc_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] period_count
);

    state_e           state_q;
    state_e           state_d;
    logic [HP_W-1:0]  hp_q;
    logic [HP_W-1:0]  hp_d;
    logic [CNT_W-1:0] n_q;
    logic [CNT_W-1:0] n_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             osc_q;
    logic             osc_d;
    logic             done_q;
    logic             done_d;
    logic             busy_q;
    logic             busy_d;
    logic             stop_pend_q;
    logic             stop_pend_d;
    logic             start_q;
    logic             start_d;

    logic             accept_s;
    logic             boundary_s;
    logic             term_s;
    logic             tmr_load_s;
    logic             tmr_zero_s;
    logic [HP_W-1:0]  tmr_val_s;
    logic [HP_W-1:0]  hp_clamp_s;
    logic [CNT_W-1:0] cnt_inc_s;

    assign cfg_ready  = (state_q == ST_IDLE);
    assign accept_s   = cfg_valid && cfg_ready;
    assign hp_clamp_s = (cfg_half_period == {HP_W{1'b0}}) ? HP_W'(HP_MIN) : cfg_half_period;
    assign cnt_inc_s  = cnt_q + CNT_W'(1);
    // A boundary is the end of a low phase; the first RUN cycle only arms the timer.
    assign boundary_s = (state_q == ST_RUN) && !start_q && tmr_zero_s && !osc_q;
    assign term_s     = ((n_q != {CNT_W{1'b0}}) && (cnt_inc_s == n_q)) || stop_pend_q || stop;
    assign tmr_load_s = (state_q == ST_RUN) && (start_q || tmr_zero_s);
    assign tmr_val_s  = hp_q - HP_W'(1);

    osc_half_period_timer #(
        .HP_W (HP_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (tmr_load_s),
        .load_val  (tmr_val_s),
        .tick_zero (tmr_zero_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (boundary_s && term_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; all outputs leave through registers.
    always_comb begin
        hp_d        = hp_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        osc_d       = osc_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        stop_pend_d = stop_pend_q;
        start_d     = start_q;
        case (state_q)
            ST_IDLE: begin
                osc_d = 1'b0;
                if (accept_s) begin
                    hp_d        = hp_clamp_s;
                    n_d         = cfg_periods;
                    cnt_d       = {CNT_W{1'b0}};
                    busy_d      = 1'b1;
                    stop_pend_d = 1'b0;
                    start_d     = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end else begin
                    stop_pend_d = stop_pend_q;
                end
                if (start_q) begin
                    osc_d   = 1'b1;
                    start_d = 1'b0;
                end else if (tmr_zero_s && osc_q) begin
                    osc_d = 1'b0;
                end else if (boundary_s) begin
                    cnt_d = cnt_inc_s;
                    if (term_s) begin
                        osc_d  = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        osc_d = 1'b1;
                    end
                end else begin
                    osc_d = osc_q;
                end
            end
            ST_DONE: begin
                osc_d       = 1'b0;
                busy_d      = 1'b0;
                stop_pend_d = 1'b0;
                start_d     = 1'b0;
            end
            default: begin
                osc_d       = 1'b0;
                busy_d      = 1'b0;
                stop_pend_d = 1'b0;
                start_d     = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hp_q        <= {HP_W{1'b0}};
            n_q         <= {CNT_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            osc_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            hp_q        <= hp_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            osc_q       <= osc_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            stop_pend_q <= stop_pend_d;
            start_q     <= start_d;
        end
    end

    assign osc_out      = osc_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign period_count = cnt_q;

endmodule
